// File: rtl/add_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : add_serial_pkg
//  Purpose : Shared definitions for the digit-serial adder/subtractor:
//            the 2-bit controller state type with its encodings, and a
//            ceiling-log2 helper used to size the digit counter.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package add_serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADD  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // ceil(log2(n)), but never below 1 so a counter always has a bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage : add_serial_pkg
`default_nettype wire

// File: rtl/serial_digit_add.sv
`default_nettype none
// ============================================================================
//  Module  : serial_digit_add
//  Purpose : Combinational DIGIT-bit adder slice for the serial datapath.
//  Ports   : x, y   - DIGIT-bit addends
//            cin    - carry into bit 0
//            sum    - DIGIT-bit sum
//            cout   - carry out of the digit MSB
//            c_msb  - carry into the digit MSB (for overflow detection)
//  Rev     : 1.0  initial release
// ============================================================================
module serial_digit_add #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] w_full;

   assign w_full = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(cin);
   assign sum    = w_full[DIGIT-1:0];
   assign cout   = w_full[DIGIT];
   // The MSB sum bit is x^y^carry_in, so the carry into it falls out directly.
   assign c_msb  = w_full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule : serial_digit_add
`default_nettype wire

// File: rtl/add_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module  : add_sub_serial
//  Purpose : Digit-serial adder/subtractor. WIDTH-bit operands are processed
//            DIGIT bits per clock, LSB first, over N = WIDTH/DIGIT cycles.
//            Subtraction is a + ~b + 1 (carry pre-loaded with 1).
//  Ports   : clk, rst        - clock (rising), async active-high reset
//            start/ready     - request handshake (ready only in IDLE)
//            sub, a, b       - mode and operands, sampled at accept
//            busy            - high while digits are being processed
//            valid/ack       - result handshake (valid only in DONE)
//            out, cout, ovf  - result, carry-out (sub: 1 = no borrow),
//                              two's-complement overflow
//  Rev     : 1.0  initial release
// ============================================================================
module add_sub_serial
   import add_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   input  logic             ack,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf
);

   localparam int              N      = WIDTH / DIGIT;
   localparam int              CW     = clog2_min1(N);
   localparam logic [CW-1:0]   C_LAST = CW'(N - 1);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_out;
   logic [CW-1:0]      r_count;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;

   logic [DIGIT-1:0]   w_sum;
   logic               w_c;
   logic               w_cmsb;
   logic               w_last;

   serial_digit_add #(.DIGIT(DIGIT)) u_digit (
      .x     (r_a[DIGIT-1:0]),
      .y     (r_b[DIGIT-1:0]),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_c),
      .c_msb (w_cmsb)
   );

   assign w_last = (r_count == C_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_next = ST_ADD;
         ST_ADD:  if (w_last) w_next = ST_DONE;
         ST_DONE: if (ack)    w_next = ST_IDLE;
         default:             w_next = ST_IDLE;
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      ready = (r_state == ST_IDLE);
      busy  = (r_state == ST_ADD);
      valid = (r_state == ST_DONE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_count <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub;
                  r_count <= '0;
                  r_out   <= '0;
               end
            end
            ST_ADD: begin
               // New digit enters at the top; after N digits the LSB digit
               // has walked down to bit 0.
               r_out   <= WIDTH'({w_sum, r_out} >> DIGIT);
               r_carry <= w_c;
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_count <= r_count + CW'(1);
               if (w_last) begin
                  r_cout <= w_c;
                  r_ovf  <= w_cmsb ^ w_c;
               end
            end
            default: ; // DONE and the illegal encoding hold every register
         endcase
      end
   end

   assign out  = r_out;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule : add_sub_serial
`default_nettype wire

// File: tb/tb_add_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module  : tb_add_sub_serial
//  Purpose : Self-checking bench for add_sub_serial. Five instances:
//            WIDTH=8 with DIGIT 1/2/4/8, and WIDTH=16 with DIGIT=4.
//            Expected results come from plain-integer arithmetic and are
//            queued at issue time; a monitor pops them when valid rises.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_add_sub_serial;

   localparam int NI = 5;

   typedef struct {
      logic [15:0] o;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start_s [NI];
   logic        sub_s   [NI];
   logic [15:0] a_s     [NI];
   logic [15:0] b_s     [NI];
   logic        ack_s   [NI];
   logic        ready_s [NI];
   logic        busy_s  [NI];
   logic        valid_s [NI];
   logic [15:0] out_s   [NI];
   logic        cout_s  [NI];
   logic        ovf_s   [NI];

   exp_t        q       [NI][$];
   int          t_acc   [NI];
   int          bcnt    [NI];
   logic        vprev   [NI];
   int          cyc;
   int          n_tests;
   int          n_fail;

   function automatic int wof(input int k);
      return (k == 4) ? 16 : 8;
   endfunction

   function automatic int dof(input int k);
      case (k)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         3:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int nof(input int k);
      return wof(k) / dof(k);
   endfunction

   // Reference: modular sum/difference, unsigned carry/no-borrow, and
   // signed-range overflow, all from plain integer arithmetic.
   function automatic exp_t model(input int k, input bit s,
                                  input logic [15:0] x, input logic [15:0] y);
      exp_t   e;
      longint m, ux, uy, r, sx, sy, sr;
      m  = longint'(1) << wof(k);
      ux = longint'(x) % m;
      uy = longint'(y) % m;
      sx = (ux >= m / 2) ? ux - m : ux;
      sy = (uy >= m / 2) ? uy - m : uy;
      if (!s) begin
         r   = ux + uy;
         e.c = (r >= m);
         sr  = sx + sy;
      end else begin
         r   = ux - uy + m;
         e.c = (ux >= uy);
         sr  = sx - sy;
      end
      e.o = 16'(r % m);
      e.v = (sr < -(m / 2)) || (sr >= m / 2);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- DUT instances ----------------
   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int W = (k == 4) ? 16 : 8;
      localparam int D = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : (k == 3) ? 8 : 4;
      logic [W-1:0] w_out;

      add_sub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_s[k]),
         .sub   (sub_s[k]),
         .a     (a_s[k][W-1:0]),
         .b     (b_s[k][W-1:0]),
         .ready (ready_s[k]),
         .busy  (busy_s[k]),
         .valid (valid_s[k]),
         .ack   (ack_s[k]),
         .out   (w_out),
         .cout  (cout_s[k]),
         .ovf   (ovf_s[k])
      );
      assign out_s[k] = 16'(w_out);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      for (int k = 0; k < NI; k++) begin
         vprev[k] = 1'b0;
         bcnt[k]  = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (rst) begin
               vprev[k] = 1'b0;
               bcnt[k]  = 0;
            end else begin
               if (busy_s[k]) bcnt[k]++;
               if (valid_s[k] && !vprev[k]) begin
                  if (q[k].size() == 0) begin
                     chk($sformatf("unexpected_valid[%0d]", k), 32'd1, 32'd0);
                  end else begin
                     e = q[k].pop_front();
                     chk($sformatf("out[%0d]", k),  32'(out_s[k]), 32'(e.o));
                     chk($sformatf("cout[%0d]", k), 32'(cout_s[k]), 32'(e.c));
                     chk($sformatf("ovf[%0d]", k),  32'(ovf_s[k]), 32'(e.v));
                     chk($sformatf("latency[%0d]", k), 32'(cyc - t_acc[k]), 32'(nof(k)));
                     chk($sformatf("busy_cycles[%0d]", k), 32'(bcnt[k]), 32'(nof(k)));
                  end
                  bcnt[k] = 0;
               end
               vprev[k] = valid_s[k];
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input int k, input bit s, input logic [15:0] x, input logic [15:0] y);
      int guard;
      guard = 0;
      while (!ready_s[k] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ready_s[k]) chk($sformatf("ready_timeout[%0d]", k), 32'd0, 32'd1);
      start_s[k] = 1'b1;
      sub_s[k]   = s;
      a_s[k]     = x;
      b_s[k]     = y;
      q[k].push_back(model(k, s, x, y));
      @(negedge clk);
      t_acc[k]   = cyc;
      start_s[k] = 1'b0;
      sub_s[k]   = 1'($urandom);
      a_s[k]     = 16'($urandom);
      b_s[k]     = 16'($urandom);
   endtask

   task automatic wait_valid(input int k);
      int guard;
      guard = 0;
      while (!valid_s[k] && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!valid_s[k]) chk($sformatf("valid_timeout[%0d]", k), 32'd0, 32'd1);
   endtask

   task automatic do_ack(input int k, input int dly);
      repeat (dly) @(negedge clk);
      ack_s[k] = 1'b1;
      @(negedge clk);
      ack_s[k] = 1'b0;
   endtask

   task automatic run_op(input int k, input bit s, input logic [15:0] x,
                         input logic [15:0] y, input int dly);
      issue(k, s, x, y);
      wait_valid(k);
      do_ack(k, dly);
   endtask

   task automatic sweep(input int k, input int nops);
      for (int i = 0; i < nops; i++)
         run_op(k, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] saved;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst     = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start_s[k] = 1'b0;
         sub_s[k]   = 1'b0;
         a_s[k]     = '0;
         b_s[k]     = '0;
         ack_s[k]   = 1'b0;
         t_acc[k]   = 0;
      end
      repeat (3) @(negedge clk);

      // Reset state
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_ready[%0d]", k), 32'(ready_s[k]), 32'd1);
         chk($sformatf("rst_busy[%0d]", k),  32'(busy_s[k]),  32'd0);
         chk($sformatf("rst_valid[%0d]", k), 32'(valid_s[k]), 32'd0);
         chk($sformatf("rst_out[%0d]", k),   32'(out_s[k]),   32'd0);
         chk($sformatf("rst_cout[%0d]", k),  32'(cout_s[k]),  32'd0);
         chk($sformatf("rst_ovf[%0d]", k),   32'(ovf_s[k]),   32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // 1: W8 D1 add
      issue(0, 1'b0, 16'h3C, 16'h45);
      wait_valid(0);
      chk("t1_out", 32'(out_s[0]), 32'h81);
      chk("t1_cout", 32'(cout_s[0]), 32'd0);
      chk("t1_ovf", 32'(ovf_s[0]), 32'd1);
      do_ack(0, 0);

      // 2: W8 D1 subtracts
      run_op(0, 1'b1, 16'h10, 16'h20, 1);
      chk("t2a_out", 32'(out_s[0]), 32'hF0);
      chk("t2a_cout", 32'(cout_s[0]), 32'd0);
      chk("t2a_ovf", 32'(ovf_s[0]), 32'd0);
      run_op(0, 1'b1, 16'h80, 16'h01, 0);
      chk("t2b_out", 32'(out_s[0]), 32'h7F);
      chk("t2b_cout", 32'(cout_s[0]), 32'd1);
      chk("t2b_ovf", 32'(ovf_s[0]), 32'd1);

      // 3: W16 D4 adds
      run_op(4, 1'b0, 16'hFFFF, 16'h0001, 0);
      chk("t3a_out", 32'(out_s[4]), 32'h0000);
      chk("t3a_cout", 32'(cout_s[4]), 32'd1);
      chk("t3a_ovf", 32'(ovf_s[4]), 32'd0);
      run_op(4, 1'b0, 16'h7FFF, 16'h0001, 2);
      chk("t3b_out", 32'(out_s[4]), 32'h8000);
      chk("t3b_cout", 32'(cout_s[4]), 32'd0);
      chk("t3b_ovf", 32'(ovf_s[4]), 32'd1);

      // 4: back-pressure while start pulses with changing operands
      issue(0, 1'b0, 16'h12, 16'h34);
      wait_valid(0);
      saved = out_s[0];
      chk("t4_out", 32'(saved), 32'h46);
      for (int i = 0; i < 5; i++) begin
         start_s[0] = 1'b1;
         sub_s[0]   = 1'($urandom);
         a_s[0]     = 16'($urandom);
         b_s[0]     = 16'($urandom);
         @(negedge clk);
         chk("t4_valid_hold", 32'(valid_s[0]), 32'd1);
         chk("t4_ready_low", 32'(ready_s[0]), 32'd0);
         chk("t4_out_hold", 32'(out_s[0]), 32'(saved));
      end
      start_s[0] = 1'b0;
      ack_s[0]   = 1'b1;
      @(negedge clk);
      ack_s[0]   = 1'b0;
      chk("t4_ready_after_ack", 32'(ready_s[0]), 32'd1);
      chk("t4_out_after_ack", 32'(out_s[0]), 32'(saved));
      run_op(0, 1'b1, 16'h05, 16'h03, 0);
      chk("t4_new_out", 32'(out_s[0]), 32'h02);

      // 5: reset in the middle of an operation
      issue(0, 1'b0, 16'hFF, 16'h00);
      repeat (3) @(negedge clk);
      chk("t5_busy_before", 32'(busy_s[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_out", 32'(out_s[0]), 32'd0);
      chk("t5_cout", 32'(cout_s[0]), 32'd0);
      chk("t5_ovf", 32'(ovf_s[0]), 32'd0);
      chk("t5_valid", 32'(valid_s[0]), 32'd0);
      chk("t5_ready", 32'(ready_s[0]), 32'd1);
      q[0].delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(0, 1'b0, 16'h01, 16'h01, 0);
      chk("t5_post_out", 32'(out_s[0]), 32'h02);

      // 6: random sweep on all instances concurrently
      fork
         sweep(0, 1000);
         sweep(1, 1000);
         sweep(2, 1000);
         sweep(3, 1000);
         sweep(4, 300);
      join

      repeat (2) @(negedge clk);
      for (int k = 0; k < NI; k++)
         chk($sformatf("queue_drained[%0d]", k), 32'(q[k].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_add_sub_serial
`default_nettype wire
